timer_irq_ctrl: RTL and testbench

Machine-timer interrupt controller that sits beside the memory-mapped timer on the peripheral bus. It holds a staged/committed 64-bit compare value, compares it against the CPU core's 64-bit cycle counter through a two-stage pipeline, and drives a pending-interrupt flag and the machine timer interrupt line into the core. A two-write commit protocol keeps a half-updated compare value from raising a spurious interrupt.

---
 rtl/timer_irq_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_timer_irq_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : timer_irq_ctrl
// Purpose  : Machine-timer interrupt controller. Holds a staged/committed
//            64-bit compare value, compares it against the core cycle counter
//            through a two-stage pipeline and drives the pending flag and the
//            machine timer interrupt line. A two-write commit (CMPL then CMPH)
//            keeps a half-updated compare from raising a spurious interrupt.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk            core clock
//   reset_         asynchronous active-low reset
//   cycle_in       64-bit free-running cycle count from the core
//   address_in     bus address, only [3:2] decoded
//   sel_in         block selected this cycle
//   read_in        read strobe (reads have no side effects)
//   read_value_out combinational read data, 0 when not selected
//   write_mask_in  byte enables; any set bit with sel_in makes a write
//   write_value_in write data
//   irq_out        machine timer interrupt to the core
// Register map (address_in[3:2]):
//   00 CMPL  staged low word   (R/W, byte-masked)
//   01 CMPH  staged high word  (R/W, byte-masked, write commits compare)
//   10 CTRL  [0] IE, [1] PENDING (W1C), [3:2] state (RO)
//   11 reserved (reads 0, writes ignored)
// Configuration:
//   TIMER_IRQ_ONESHOT_EN  defined   -> first match moves to FIRED, one-shot
//                         undefined -> level mode, standard mtimecmp semantics
// ============================================================================
module timer_irq_ctrl (
    input  logic        clk,
    input  logic        reset_,
    input  logic [63:0] cycle_in,
    input  logic [31:0] address_in,
    input  logic        sel_in,
    input  logic        read_in,
    output logic [31:0] read_value_out,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] write_value_in,
    output logic        irq_out
);

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_STAGED   = 2'd1,
        ST_ARMED    = 2'd2,
        ST_FIRED    = 2'd3
    } state_t;

    localparam logic [1:0] c_ADDR_CMPL = 2'd0;
    localparam logic [1:0] c_ADDR_CMPH = 2'd1;
    localparam logic [1:0] c_ADDR_CTRL = 2'd2;

    state_t      r_state;
    logic [31:0] r_cmpl;
    logic [31:0] r_cmph;
    logic [63:0] r_cmp;
    logic        r_ie;
    logic        r_pending;
    logic        r_s1_valid;
    logic        r_hi_gt;
    logic        r_hi_eq;
    logic        r_lo_ge;
    logic        r_match;

    logic        w_write;
    logic        w_wr_cmpl;
    logic        w_wr_cmph;
    logic        w_wr_ctrl;
    logic        w_w1c;
    logic        w_cmp_live;
    logic [31:0] w_cmpl_merged;
    logic [31:0] w_cmph_merged;
    logic        w_unused;

    // Reads have no side effects and only [3:2] of the address is decoded.
    assign w_unused = &{1'b0, read_in, address_in[31:4], address_in[1:0]};

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  mask);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = mask[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
        end
        return res;
    endfunction

    assign w_write       = sel_in && (|write_mask_in);
    assign w_wr_cmpl     = w_write && (address_in[3:2] == c_ADDR_CMPL);
    assign w_wr_cmph     = w_write && (address_in[3:2] == c_ADDR_CMPH);
    assign w_wr_ctrl     = w_write && (address_in[3:2] == c_ADDR_CTRL);
    assign w_w1c         = w_wr_ctrl && write_mask_in[0] && write_value_in[1];
    assign w_cmpl_merged = merge_bytes(r_cmpl, write_value_in, write_mask_in);
    assign w_cmph_merged = merge_bytes(r_cmph, write_value_in, write_mask_in);

    // The compare pipeline only carries valid data while ARMED and no compare
    // register is being touched; anything else flushes both stages so compare
    // restarts from freshly sampled values.
    assign w_cmp_live = (r_state == ST_ARMED) && !w_wr_cmpl && !w_wr_cmph;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state    <= ST_DISARMED;
            r_cmpl     <= 32'hFFFF_FFFF;
            r_cmph     <= 32'hFFFF_FFFF;
            r_cmp      <= 64'hFFFF_FFFF_FFFF_FFFF;
            r_ie       <= 1'b0;
            r_pending  <= 1'b0;
            r_s1_valid <= 1'b0;
            r_hi_gt    <= 1'b0;
            r_hi_eq    <= 1'b0;
            r_lo_ge    <= 1'b0;
            r_match    <= 1'b0;
        end else begin
            if (w_wr_cmpl) begin
                r_cmpl <= w_cmpl_merged;
            end
            if (w_wr_cmph) begin
                r_cmph <= w_cmph_merged;
                r_cmp  <= {w_cmph_merged, r_cmpl};
            end
            if (w_wr_ctrl && write_mask_in[0]) begin
                r_ie <= write_value_in[0];
            end

            // Stage 1: split 64-bit compare into word-level flags.
            r_hi_gt    <= cycle_in[63:32] >  r_cmp[63:32];
            r_hi_eq    <= cycle_in[63:32] == r_cmp[63:32];
            r_lo_ge    <= cycle_in[31:0]  >= r_cmp[31:0];
            r_s1_valid <= w_cmp_live;

            // Stage 2: combine into the 64-bit unsigned >= result.
            r_match <= w_cmp_live && r_s1_valid &&
                       (r_hi_gt || (r_hi_eq && r_lo_ge));

`ifdef TIMER_IRQ_ONESHOT_EN
            // One-shot: a trailing match after FIRED must not re-set, and a
            // software clear beats a coincident match.
            if (w_w1c) begin
                r_pending <= 1'b0;
            end else if (r_match && (r_state == ST_ARMED)) begin
                r_pending <= 1'b1;
            end
`else
            // Level: a live match keeps PENDING set even against a clear.
            if (r_match) begin
                r_pending <= 1'b1;
            end else if (w_w1c) begin
                r_pending <= 1'b0;
            end
`endif

            if (w_wr_cmpl) begin
                r_state <= ST_STAGED;
            end else if (w_wr_cmph) begin
                r_state <= ST_ARMED;
`ifdef TIMER_IRQ_ONESHOT_EN
            end else if ((r_state == ST_ARMED) && r_match) begin
                r_state <= ST_FIRED;
`endif
            end
        end
    end

    always_comb begin
        read_value_out = 32'h0;
        if (sel_in) begin
            case (address_in[3:2])
                c_ADDR_CMPL: read_value_out = r_cmpl;
                c_ADDR_CMPH: read_value_out = r_cmph;
                c_ADDR_CTRL: read_value_out = {28'h0, r_state, r_pending, r_ie};
                default:     read_value_out = 32'h0;
            endcase
        end
    end

    assign irq_out = r_pending && r_ie;

endmodule
`default_nettype wire

// File: tb/tb_timer_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_irq_ctrl
// Purpose  : Self-checking bench for timer_irq_ctrl. A cycle-level model
//            tracks register contents, state and the 2-cycle compare latency
//            as plain 64-bit arithmetic; a compare process checks irq_out and
//            read_value_out against it every cycle, and directed sequences
//            pin the model with hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer_irq_ctrl;

`ifdef TIMER_IRQ_ONESHOT_EN
    localparam bit ONESHOT = 1'b1;
`else
    localparam bit ONESHOT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_;
    logic [63:0] cycle_in;
    logic [31:0] address_in;
    logic        sel_in;
    logic        read_in;
    logic [31:0] read_value_out;
    logic [3:0]  write_mask_in;
    logic [31:0] write_value_in;
    logic        irq_out;

    int checks = 0;
    int errors = 0;

    timer_irq_ctrl dut (
        .clk            (clk),
        .reset_         (reset_),
        .cycle_in       (cycle_in),
        .address_in     (address_in),
        .sel_in         (sel_in),
        .read_in        (read_in),
        .read_value_out (read_value_out),
        .write_mask_in  (write_mask_in),
        .write_value_in (write_value_in),
        .irq_out        (irq_out)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model. m_hit_prev: this cycle's cycle_in >= compare was
    // seen last cycle while eligible; m_match: a match is visible now.
    // A hit becomes a match only if the next cycle is also eligible.
    // ------------------------------------------------------------------
    logic [31:0] m_cmpl     = 32'hFFFF_FFFF;
    logic [31:0] m_cmph     = 32'hFFFF_FFFF;
    logic [63:0] m_cmp      = 64'hFFFF_FFFF_FFFF_FFFF;
    bit          m_ie       = 1'b0;
    bit          m_pend     = 1'b0;
    bit          m_match    = 1'b0;
    bit          m_hit_prev = 1'b0;
    logic [1:0]  m_state    = 2'd0;

    function automatic logic [31:0] bytemerge(input logic [31:0] o,
                                              input logic [31:0] n,
                                              input logic [3:0]  m);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = m[i] ? n[i*8 +: 8] : o[i*8 +: 8];
        return r;
    endfunction

    always @(posedge clk or negedge reset_) begin
        bit         wr, eligible, hit, w1c, nxt_pend;
        logic [1:0] a;
        if (!reset_) begin
            m_cmpl = 32'hFFFF_FFFF; m_cmph = 32'hFFFF_FFFF;
            m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
            m_ie = 0; m_pend = 0; m_match = 0; m_hit_prev = 0; m_state = 2'd0;
        end else begin
            wr       = sel_in && (write_mask_in != 4'h0);
            a        = address_in[3:2];
            eligible = (m_state == 2'd2) && !(wr && (a == 2'd0 || a == 2'd1));
            hit      = eligible && (cycle_in >= m_cmp);
            w1c      = wr && a == 2'd2 && write_mask_in[0] && write_value_in[1];
            nxt_pend = m_pend;
            if (ONESHOT) begin
                if (m_match && m_state == 2'd2) nxt_pend = 1;
                if (w1c) nxt_pend = 0;
            end else begin
                if (w1c) nxt_pend = 0;
                if (m_match) nxt_pend = 1;
            end
            if (ONESHOT && m_state == 2'd2 && m_match && !(wr && a <= 2'd1))
                m_state = 2'd3;
            if (wr && a == 2'd0) begin
                m_cmpl  = bytemerge(m_cmpl, write_value_in, write_mask_in);
                m_state = 2'd1;
            end
            if (wr && a == 2'd1) begin
                m_cmph  = bytemerge(m_cmph, write_value_in, write_mask_in);
                m_cmp   = {m_cmph, m_cmpl};
                m_state = 2'd2;
            end
            if (wr && a == 2'd2 && write_mask_in[0]) m_ie = write_value_in[0];
            m_pend     = nxt_pend;
            m_match    = eligible && m_hit_prev;
            m_hit_prev = hit;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [31:0] exp_rd;
        bit          exp_irq;
        exp_irq = m_pend && m_ie;
        exp_rd  = 32'h0;
        if (sel_in) begin
            case (address_in[3:2])
                2'd0:    exp_rd = m_cmpl;
                2'd1:    exp_rd = m_cmph;
                2'd2:    exp_rd = {28'h0, m_state, m_pend, m_ie};
                default: exp_rd = 32'h0;
            endcase
        end
        checks++;
        if (irq_out !== exp_irq) begin
            errors++;
            $display("FAIL model_irq t=%0t actual=%b expected=%b", $time, irq_out, exp_irq);
        end
        checks++;
        if (read_value_out !== exp_rd) begin
            errors++;
            $display("FAIL model_rdata t=%0t actual=%h expected=%h", $time, read_value_out, exp_rd);
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus helpers
    // ------------------------------------------------------------------
    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] m, input logic [31:0] v);
        sel_in = 1; read_in = 0; address_in = {28'h0, a, 2'b00};
        write_mask_in = m; write_value_in = v;
        cyc();
        sel_in = 0; write_mask_in = 4'h0; write_value_in = 32'h0;
    endtask

    task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
        sel_in = 1; read_in = 1; write_mask_in = 4'h0; address_in = {28'h0, a, 2'b00};
        @(negedge clk);
        lit(name, read_value_out, exp);
        cyc();
        sel_in = 0; read_in = 0;
    endtask

    task automatic irq_is(input string name, input bit exp);
        @(negedge clk);
        lit(name, {31'h0, irq_out}, {31'h0, exp});
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_ = 0; cycle_in = 64'h0; address_in = 32'h0; sel_in = 0;
        read_in = 0; write_mask_in = 4'h0; write_value_in = 32'h0;
        repeat (3) @(posedge clk);
        #1 reset_ = 1;
        irq_is("reset_irq", 0);
        rd("reset_ctrl", 2'd2, 32'h0);

        // Byte masks: only bytes 0 and 2 land.
        wr(2'd0, 4'b0101, 32'hAABB_CCDD);
        rd("bytemask_cmpl", 2'd0, 32'hFFBB_FFDD);
        rd("staged_ctrl", 2'd2, 32'h4);
        wr(2'd3, 4'hF, 32'hFFFF_FFFF);
        rd("reserved_read", 2'd3, 32'h0);

        // Basic fire: compare = 100, ramp from 90, IRQ three cycles after 100.
        wr(2'd0, 4'hF, 32'd100);
        wr(2'd1, 4'hF, 32'd0);
        wr(2'd2, 4'hF, 32'h1);
        rd("armed_ctrl", 2'd2, 32'h9);
        for (int i = 90; i <= 110; i++) begin
            cycle_in = 64'(i);
            irq_is($sformatf("fire_ramp_%0d", i), i >= 103);
        end
        rd("fired_ctrl", 2'd2, ONESHOT ? 32'h0F : 32'h0B);

        // Asynchronous reset in the middle of a cycle.
        @(posedge clk);
        #3 reset_ = 0;
        #1 lit("async_reset_irq", {31'h0, irq_out}, 32'h0);
        @(posedge clk);
        #1 reset_ = 1; cycle_in = 64'h0;
        rd("post_reset_ctrl", 2'd2, 32'h0);
        rd("post_reset_cmpl", 2'd0, 32'hFFFF_FFFF);
        rd("post_reset_cmph", 2'd1, 32'hFFFF_FFFF);

        // Half-update guard.
        cycle_in = 64'h0_FFFF_FFF0;
        wr(2'd0, 4'hF, 32'h0);
        wr(2'd1, 4'hF, 32'h1);
        wr(2'd2, 4'hF, 32'h1);
        repeat (4) irq_is("armed_below", 0);
        wr(2'd0, 4'hF, 32'h0);
        cycle_in = 64'h1_8000_0000;   // above the still-live compare
        repeat (6) irq_is("staged_suppressed", 0);
        rd("half_staged_ctrl", 2'd2, 32'h5);
        wr(2'd1, 4'hF, 32'h2);
        repeat (6) irq_is("recommit_below", 0);

        // High-word carry: 0x1_FFFF_FFFF -> 0x2_0000_0000.
        cycle_in = 64'h1_FFFF_FFFF;
        repeat (4) irq_is("carry_before", 0);
        for (int k = 0; k < 6; k++) begin
            if (k == 0) cycle_in = 64'h2_0000_0000;
            irq_is($sformatf("carry_step_%0d", k), k >= 3);
        end

        // W1C against a held match.
        wr(2'd2, 4'hF, 32'h3);
        if (ONESHOT) begin
            repeat (10) irq_is("oneshot_no_reassert", 0);
            rd("oneshot_ctrl", 2'd2, 32'h0D);
        end else begin
            irq_is("level_w1c_held", 1);
            rd("level_w1c_ctrl", 2'd2, 32'h0B);
        end

        // Without a match the clear sticks; IE gates the line.
        cycle_in = 64'h0;
        repeat (3) irq_is("latched_after_drop", !ONESHOT);
        wr(2'd2, 4'hF, 32'h3);
        irq_is("cleared", 0);
        wr(2'd2, 4'hF, 32'h0);
        cycle_in = 64'h2_0000_0000;
        repeat (5) irq_is("ie_gated", 0);
        rd("ie_off_ctrl", 2'd2, ONESHOT ? 32'h0C : 32'h0A);

        repeat (2) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
